// File: rtl/instr_decode_pkg.sv
// instr_decode_pkg: shared opcode/funct7 constants, alu_op layout and stage state type
package instr_decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    typedef struct packed {
        logic       m_ext;
        logic       alt;
        logic [2:0] funct3;
    } alu_op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/instr_decode_comb.sv
// instr_decode_comb: purely combinational field extraction and legality decode
module instr_decode_comb
    import instr_decode_pkg::*;
#(
    parameter int IMM_W = 32
) (
    input  logic [31:0]      instr,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             reg_write,
    output logic [4:0]       alu_op,
    output logic             use_imm,
    output logic [IMM_W-1:0] imm,
    output logic             illegal
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       is_op;
    logic       is_op_imm;
    logic       op_ok;
    logic       op_imm_ok;
    logic       legal;
    alu_op_t    op;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    assign is_op     = opcode == OPC_OP;
    assign is_op_imm = opcode == OPC_OP_IMM;

    // The alternate encoding only exists for SUB and SRA.
    assign op_ok = funct7 == F7_BASE || funct7 == F7_MULDIV
                || (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA));

    // Only the shift-immediates constrain the upper bits; elsewhere they are immediate.
    assign op_imm_ok = funct3 == F3_SLL     ? funct7 == F7_BASE
                     : funct3 == F3_SRL_SRA ? (funct7 == F7_BASE || funct7 == F7_ALT)
                     : 1'b1;

    assign legal   = (is_op && op_ok) || (is_op_imm && op_imm_ok);
    assign illegal = !legal;

    assign op.m_ext  = is_op && funct7 == F7_MULDIV;
    assign op.alt    = funct7 == F7_ALT && (is_op || funct3 == F3_SRL_SRA);
    assign op.funct3 = funct3;

    assign alu_op    = legal ? op : '0;
    assign use_imm   = legal && is_op_imm;
    assign imm       = use_imm ? {{(IMM_W-12){instr[31]}}, instr[31:20]} : '0;
    assign reg_write = legal && rd != 5'd0;

endmodule

// File: rtl/instr_decode.sv
// instr_decode: registered RV32 I/M decode stage with valid/ready handshake
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter int IMM_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             reg_write,
    output logic [4:0]       alu_op,
    output logic             use_imm,
    output logic [IMM_W-1:0] imm,
    output logic             illegal,
    output logic [CNT_W-1:0] ill_count
);

    logic [4:0]       d_rs1;
    logic [4:0]       d_rs2;
    logic [4:0]       d_rd;
    logic             d_reg_write;
    logic [4:0]       d_alu_op;
    logic             d_use_imm;
    logic [IMM_W-1:0] d_imm;
    logic             d_illegal;
    logic             accept;
    state_t           state;
    state_t           next_state;

    instr_decode_comb #(.IMM_W(IMM_W)) u_comb (
        .instr     (instr),
        .rs1       (d_rs1),
        .rs2       (d_rs2),
        .rd        (d_rd),
        .reg_write (d_reg_write),
        .alu_op    (d_alu_op),
        .use_imm   (d_use_imm),
        .imm       (d_imm),
        .illegal   (d_illegal)
    );

    assign out_valid = state == FULL;
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // Valid bit: register holds a bundle until downstream takes it.
    always_ff @(posedge clk) begin
        state <= !reset ? EMPTY : next_state;
    end

    // Fill on accept (including accept-while-draining), empty on a drain with nothing new.
    always_comb begin
        next_state = state;
        next_state = accept ? FULL : (out_ready ? EMPTY : state);
    end

    // Pipeline register for the decoded bundle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            reg_write <= 1'b0;
            alu_op    <= '0;
            use_imm   <= 1'b0;
            imm       <= '0;
            illegal   <= 1'b0;
        end else if (accept) begin
            rs1       <= d_rs1;
            rs2       <= d_rs2;
            rd        <= d_rd;
            reg_write <= d_reg_write;
            alu_op    <= d_alu_op;
            use_imm   <= d_use_imm;
            imm       <= d_imm;
            illegal   <= d_illegal;
        end
    end

    // Saturating count of illegal instructions taken into the stage.
    always_ff @(posedge clk) begin
        if (!reset)
            ill_count <= '0;
        else if (accept && d_illegal && ill_count != '1)
            ill_count <= ill_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: randomized and directed checks of instr_decode against a spec-level model
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write;
    logic [4:0]  alu_op;
    logic        use_imm;
    logic [31:0] imm;
    logic        illegal;
    logic [7:0]  ill_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic [4:0]  op;
        logic        ui;
        logic [31:0] imm;
        logic        ill;
    } bundle_t;

    bundle_t m_b;
    logic    m_valid;
    logic    m_zero;
    int      m_cnt;

    instr_decode dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .reg_write (reg_write),
        .alu_op    (alu_op),
        .use_imm   (use_imm),
        .imm       (imm),
        .illegal   (illegal),
        .ill_count (ill_count)
    );

    always #5 clk = !clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode written straight from the instruction-set rules.
    function automatic bundle_t ref_dec(input logic [31:0] i);
        bundle_t b;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic ok, m, alt;
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        ok  = 1'b0;
        m   = 1'b0;
        alt = 1'b0;
        b   = '0;
        b.rs1 = i[19:15];
        b.rs2 = i[24:20];
        b.rd  = i[11:7];
        if (opc == 7'h33) begin
            if (f7 == 7'h00) ok = 1'b1;
            else if (f7 == 7'h01) begin ok = 1'b1; m = 1'b1; end
            else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin ok = 1'b1; alt = 1'b1; end
            if (ok) b.op = {m, alt, f3};
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1) ok = (f7 == 7'h00);
            else if (f3 == 3'd5) begin
                ok  = (f7 == 7'h00) || (f7 == 7'h20);
                alt = (f7 == 7'h20);
            end else ok = 1'b1;
            if (ok) begin
                b.op  = {1'b0, alt, f3};
                b.ui  = 1'b1;
                b.imm = 32'(int'($signed(i[31:20])));
            end
        end
        b.ill = !ok;
        b.rw  = ok && (i[11:7] != 5'd0);
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        int s;
        r = $urandom;
        k = $urandom_range(0, 9);
        s = $urandom_range(0, 3);
        if (k <= 4) begin
            r[6:0] = 7'h33;
            r[31:25] = (s == 0) ? 7'h00 : (s == 1) ? 7'h20 : (s == 2) ? 7'h01 : r[31:25];
        end else if (k <= 8) begin
            r[6:0] = 7'h13;
            r[31:25] = (s == 0) ? 7'h00 : (s == 1) ? 7'h20 : r[31:25];
        end
        if ($urandom_range(0, 4) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    task automatic compare_outputs();
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        check("ill_count", 64'(ill_count), 64'(m_cnt));
        if (m_valid || m_zero) begin
            check("rs1", 64'(rs1), 64'(m_b.rs1));
            check("rs2", 64'(rs2), 64'(m_b.rs2));
            check("rd", 64'(rd), 64'(m_b.rd));
            check("reg_write", 64'(reg_write), 64'(m_b.rw));
            check("alu_op", 64'(alu_op), 64'(m_b.op));
            check("use_imm", 64'(use_imm), 64'(m_b.ui));
            check("imm", 64'(imm), 64'(m_b.imm));
            check("illegal", 64'(illegal), 64'(m_b.ill));
        end
    endtask

    // One cycle: drive at negedge, compare just after, advance model at posedge.
    task automatic step(input logic rst, input logic iv, input logic [31:0] ins, input logic ordy);
        bundle_t e;
        logic acc;
        reset     = rst;
        in_valid  = iv;
        instr     = ins;
        out_ready = ordy;
        #1;
        compare_outputs();
        @(posedge clk);
        if (!rst) begin
            m_valid = 1'b0;
            m_zero  = 1'b1;
            m_b     = '0;
            m_cnt   = 0;
        end else begin
            acc = iv && (!m_valid || ordy);
            if (acc) begin
                e       = ref_dec(ins);
                m_b     = e;
                m_valid = 1'b1;
                m_zero  = 1'b0;
                if (e.ill && m_cnt != 255) m_cnt++;
            end else if (ordy) m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_valid = 1'b0;
        m_zero  = 1'b1;
        m_b     = '0;
        m_cnt   = 0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ill_count", 64'(ill_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        step(1, 1, 32'h00208033, 1);
        check("x0_rd", 64'(rd), 64'd0);
        check("x0_reg_write", 64'(reg_write), 64'd0);
        step(1, 1, 32'h003110b3, 1);
        check("sll_alu_op", 64'(alu_op), 64'h01);
        step(1, 1, 32'h025201b3, 1);
        check("mul_alu_op", 64'(alu_op), 64'h10);
        step(1, 1, 32'hffba8a13, 1);
        check("addi_imm", 64'(imm), 64'hFFFFFFFB);
        check("addi_rd", 64'(rd), 64'd20);
        step(1, 1, 32'h017b1a93, 1);
        check("slli_imm", 64'(imm), 64'd23);
        step(1, 1, 32'h002c5b93, 1);
        check("srli_alu_op", 64'(alu_op), 64'h05);
        step(1, 0, 32'h0, 1);

        step(1, 1, 32'h00a50533, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 32'h40b585b3, 0);
        step(1, 1, 32'h40b585b3, 1);
        step(1, 1, 32'h00c60613, 1);
        step(1, 0, 32'h0, 1);

        step(1, 1, 32'h00000073, 1);
        check("ill_sys", 64'(illegal), 64'd1);
        step(1, 1, 32'hFE208033, 1);
        check("ill_f7", 64'(illegal), 64'd1);
        check("ill_f7_rw", 64'(reg_write), 64'd0);
        check("ill_cnt2", 64'(ill_count), 64'd2);
        for (int i = 0; i < 300; i++) step(1, 1, 32'h00000073, 1);
        check("ill_sat", 64'(ill_count), 64'd255);
        step(1, 0, 32'h0, 1);

        step(1, 1, 32'h00208133, 0);
        step(1, 1, 32'h00208133, 0);
        step(0, 0, 32'h0, 0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_cnt", 64'(ill_count), 64'd0);
        step(1, 1, 32'h00310093, 1);
        step(1, 0, 32'h0, 1);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7);
        step(1, 0, 32'h0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
